// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// Opcodes, FSM states and datapath select codes.
package ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_IMM = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/branch_cond.sv
// Branch resolution from funct3 and the ALU flags of a SUB.
// Flags: bit0 Z, bit1 N, bit2 C (no borrow), bit3 V.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic [3:0] flags,
    output logic       taken
);

    logic z, n, c, v;

    assign z = flags[0];
    assign n = flags[1];
    assign c = flags[2];
    assign v = flags[3];

    // Compare result per branch type; 010/011 never reach here legally
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = z;
            3'b001:  taken = ~z;
            3'b100:  taken = n ^ v;
            3'b101:  taken = ~(n ^ v);
            3'b110:  taken = ~c;
            3'b111:  taken = c;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
// with ready-based memory handshake and bus timeout.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 4,
    parameter int STATUS_W = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic [STATUS_W-1:0] status,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pcsrc,
    output logic                alusrc,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [1:0]          wb,
    output logic                regrw,
    output logic [2:0]          immgen_ctrl,
    output logic                illegal,
    output logic                bus_err
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          set_ill, set_bus;
    logic [3:0]    alu4;
    logic [2:0]    imm_sel;
    logic          taken;

    logic [6:0] op;
    logic [2:0] f3;
    logic is_r, is_i, is_lw, is_sw;
    logic is_b, is_jal, is_jalr, legal;

    // Bits the controller never inspects
    logic [31:0]         unused_instr;
    logic [STATUS_W-1:0] unused_status;
    assign unused_instr  = instr;
    assign unused_status = status;

    assign op = instr[6:0];
    assign f3 = instr[14:12];

    assign is_r    = (op == OP_R);
    assign is_i    = (op == OP_I);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_b    = (op == OP_B);
    assign is_jal  = (op == OP_JAL);
    assign is_jalr = (op == OP_JALR);

    assign legal = is_r | is_i | is_lw | is_sw
                 | is_jal | is_jalr
                 | (is_b & (f3 != 3'b010) & (f3 != 3'b011));

    assign aluop = ALUOP_W'(alu4);

    branch_cond u_branch_cond (
        .funct3 (f3),
        .flags  (status[3:0]),
        .taken  (taken)
    );

    // Immediate format selected by opcode
    always_comb begin
        imm_sel = IMM_NONE;
        unique case (1'b1)
            is_i, is_lw, is_jalr: imm_sel = IMM_I;
            is_sw:                imm_sel = IMM_S;
            is_b:                 imm_sel = IMM_B;
            is_jal:               imm_sel = IMM_J;
            default:              imm_sel = IMM_NONE;
        endcase
    end

    // State, wait counter and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            cnt     <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (set_ill) illegal <= 1'b1;
            if (set_bus) bus_err <= 1'b1;
        end
    end

    // Next state and Moore strobes; rst forces every strobe low at once
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        set_ill     = 1'b0;
        set_bus     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pcsrc       = PCSRC_PC4;
        alusrc      = 1'b0;
        alu4        = ALU_ADD;
        wb          = WB_ALU;
        regrw       = 1'b0;
        immgen_ctrl = IMM_NONE;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        cnt_n   = '0;
                        state_n = S_DECODE;
                    end else if (cnt == CW'(WAIT_MAX)) begin
                        set_bus = 1'b1;
                        state_n = S_TRAP;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_DECODE: begin
                    immgen_ctrl = imm_sel;
                    if (legal) begin
                        state_n = S_EXEC;
                    end else begin
                        set_ill = 1'b1;
                        state_n = S_TRAP;
                    end
                end
                S_EXEC: begin
                    immgen_ctrl = imm_sel;
                    unique case (1'b1)
                        is_r: begin
                            alu4    = {instr[30], f3};
                            state_n = S_WB;
                        end
                        is_i: begin
                            alusrc  = 1'b1;
                            alu4    = {(f3 == 3'b101) & instr[30], f3};
                            state_n = S_WB;
                        end
                        is_lw, is_sw: begin
                            alusrc  = 1'b1;
                            state_n = S_MEM;
                        end
                        is_jalr: begin
                            alusrc  = 1'b1;
                            state_n = S_WB;
                        end
                        is_jal: begin
                            state_n = S_WB;
                        end
                        is_b: begin
                            alu4    = ALU_SUB;
                            pc_we   = 1'b1;
                            pcsrc   = taken ? PCSRC_IMM : PCSRC_PC4;
                            state_n = S_FETCH;
                        end
                        default: state_n = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    immgen_ctrl = imm_sel;
                    mem_req     = 1'b1;
                    mem_we      = is_sw;
                    if (mem_ready) begin
                        cnt_n = '0;
                        if (is_sw) begin
                            pc_we   = 1'b1;
                            state_n = S_FETCH;
                        end else begin
                            state_n = S_WB;
                        end
                    end else if (cnt == CW'(WAIT_MAX)) begin
                        set_bus = 1'b1;
                        state_n = S_TRAP;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_WB: begin
                    immgen_ctrl = imm_sel;
                    regrw       = 1'b1;
                    pc_we       = 1'b1;
                    unique case (1'b1)
                        is_lw: wb = WB_MEM;
                        is_jal: begin
                            wb    = WB_PC4;
                            pcsrc = PCSRC_IMM;
                        end
                        is_jalr: begin
                            wb    = WB_PC4;
                            pcsrc = PCSRC_ALU;
                        end
                        default: wb = WB_ALU;
                    endcase
                    cnt_n   = '0;
                    state_n = S_FETCH;
                end
                S_TRAP: state_n = S_TRAP;
                default: state_n = S_TRAP;
            endcase
        end
    end

endmodule
